// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int STATE_W       = 2;
  localparam int DEFAULT_WIDTH = 8;

  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] S_DONE = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: difference = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic difference,
  output logic bout
);

  assign difference = a ^ b ^ bin;
  assign bout       = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB first over WIDTH cycles using one
// full_subtractor cell and a registered borrow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_sr_q, res_sr_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               bout_q, bout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               last_bit;
  logic               cell_diff;
  logic               cell_bout;
  logic [WIDTH-1:0]   res_next;

  // Starting is allowed from IDLE and from the single DONE cycle (back-to-back operation).
  assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_bit = (cnt_q == CNT_LAST);
  assign res_next = {cell_diff, res_sr_q[WIDTH-1:1]};

  full_subtractor u_cell (
    .a          (a_sr_q[0]),
    .b          (b_sr_q[0]),
    .bin        (borrow_q),
    .difference (cell_diff),
    .bout       (cell_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = accept ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Result registers are only rewritten on the final RUN edge, so the previous
  // result stays visible while a new operation is shifting.
  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    if (accept) begin
      a_sr_d   = a;
      b_sr_d   = b;
      borrow_d = 1'b0;
      cnt_d    = '0;
    end else if (state_q == S_RUN) begin
      a_sr_d   = a_sr_q >> 1;
      b_sr_d   = b_sr_q >> 1;
      res_sr_d = res_next;
      borrow_d = cell_bout;
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_bit) begin
        diff_d = res_next;
        bout_d = cell_bout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, directed corner
// sequences and a random sweep, with results checked through a scoreboard queue.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         bout;

  int total = 0;
  int bad   = 0;

  logic [W:0] sb[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t vecs[5];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    d = x - y;
    return {(x < y), d};
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest pending expectation.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got diff=%0h bout=%0b required no done", diff, bout);
      end else begin
        logic [W:0] e;
        e = sb.pop_front();
        chk("result", {23'd0, bout, diff}, {23'd0, e});
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W:0] e,
                       input string nm);
    int n;
    a = ia;
    b = ib;
    start = 1'b1;
    sb.push_back(e);
    step();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy !== 1'b1) chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
      step();
      n++;
    end
    chk({nm, "_latency"}, n, W);
    chk({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int no_done;
    logic [W-1:0] ra, rb;

    vecs[0] = '{a: 8'h35, b: 8'h12, d: 8'h23, bo: 1'b0};
    vecs[1] = '{a: 8'h12, b: 8'h35, d: 8'hDD, bo: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'h01, d: 8'hFF, bo: 1'b1};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, bo: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h7F, d: 8'h01, bo: 1'b0};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_diff", {24'd0, diff}, 32'd0);
    chk("reset_bout", {31'd0, bout}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].a, vecs[i].b, {vecs[i].bo, vecs[i].d}, $sformatf("vec%0d", i));
      step();
      chk($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // Start pulse during RUN must be ignored.
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    sb.push_back({1'b0, 8'h0F});
    step();
    start = 1'b0;
    step();
    step();
    a = 8'hAA;
    b = 8'h55;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 3;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("ignored_start_latency", n, W);
    for (int i = 0; i < 12; i++) step();

    // Asynchronous reset between edges in the middle of RUN.
    a = 8'h3C;
    b = 8'h0F;
    start = 1'b1;
    sb.push_back({1'b0, 8'h2D});
    step();
    start = 1'b0;
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst_done", {31'd0, done}, 32'd0);
    chk("midrun_rst_diff", {24'd0, diff}, 32'd0);
    chk("midrun_rst_bout", {31'd0, bout}, 32'd0);
    sb.delete();
    step();
    step();
    rst = 1'b0;
    no_done = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) no_done++;
    end
    chk("no_activity_after_rst", no_done, 0);
    do_op(8'h3C, 8'h0F, {1'b0, 8'h2D}, "post_rst");
    step();

    // Start held high through DONE: back-to-back, old result held until final RUN edge.
    a = 8'h9A;
    b = 8'h21;
    start = 1'b1;
    sb.push_back({1'b0, 8'h79});
    step();
    a = 8'h05;
    b = 8'h07;
    sb.push_back({1'b1, 8'hFE});
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("b2b_first_latency", n, W);
    step();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      chk("b2b_hold_diff", {24'd0, diff}, 32'h79);
      chk("b2b_hold_bout", {31'd0, bout}, 32'd0);
      step();
      n++;
    end
    chk("b2b_second_latency", n, W + 1);
    step();

    // Random sweep plus boundary operands.
    for (int i = 0; i < 1500; i++) begin
      if (i < 4) begin
        ra = (i[0]) ? 8'hFF : 8'h00;
        rb = (i[1]) ? 8'hFF : 8'h00;
      end else begin
        ra = W'($urandom);
        rb = W'($urandom);
      end
      do_op(ra, rb, model(ra, rb), "sweep");
    end
    step();
    step();
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
